onewire_uart_bridge: RTL and testbench

- Half-duplex 8N1 UART engine for ESC passthrough (BLHeli bootloader/config), byte-stream in and out.
- Drives the serial bridge inputs of the serial/DSHOT pad mux: serial_tx_o feeds serial_tx_i and serial_oe_o feeds serial_oe_i.
- Samples the selected motor pad through that mux's serial_rx_o.
- Sits between the host byte FIFO (SPI/USB side) and the pad mux. Owns line turnaround, which means TX and RX never overlap.

---
 rtl/onewire_uart_pkg.sv | 24 ++
 rtl/onewire_uart_bridge_sync.sv | 35 +++
 rtl/onewire_uart_bridge.sv | 222 ++++++++++++++++++++++
 tb/tb_onewire_uart_bridge.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/onewire_uart_pkg.sv
// Shared types and constants for the one-wire UART passthrough bridge.
//   state_t        : bridge FSM states (TX and RX share one FSM for turnaround)
//   UART_DATA_BITS : data bits per 8N1 frame
//   cnt_width()    : counter width able to hold values 0 .. n-1
package onewire_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    TX_HOLD,
    RX_START,
    RX_DATA,
    RX_STOP
  } state_t;

  localparam int unsigned UART_DATA_BITS = 8;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/onewire_uart_bridge_sync.sv
// sync_falling_edge: 2-FF synchronizer for an asynchronous line plus a
// registered previous value for falling-edge detection.
//   clk_i  : sampling clock
//   rst_ni : synchronous active-low reset (all stages reset to idle-high)
//   d_i    : asynchronous line input
//   sync_o : synchronized line value
//   fall_o : high for one cycle when sync_o goes 1 -> 0
module sync_falling_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic sync_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/onewire_uart_bridge.sv
// onewire_uart_bridge: half-duplex 8N1 UART engine for ESC passthrough.
// Bytes from the host FIFO are serialized onto the motor pad through the
// serial/DSHOT pad mux; bytes sampled from the pad are returned as pulses.
// TX and RX never overlap; after a transmission the line is held idle-high
// for HOLD_CLKS cycles before the driver is released.
//   wb_clk_i       : system clock
//   wb_rst_ni      : synchronous active-low reset
//   enable_i       : passthrough active (dropping it aborts any frame)
//   tx_data_i/tx_valid_i/tx_ready_o : byte-in handshake
//   rx_data_o/rx_valid_o            : received byte, one-cycle pulse
//   rx_frame_err_o : one-cycle pulse, stop bit low, byte discarded
//   busy_o         : FSM not idle
//   serial_tx_o/serial_oe_o : line drive value / drive enable
//   serial_rx_i    : asynchronous line sample
module onewire_uart_bridge
  import onewire_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 3750,
  parameter int unsigned HOLD_CLKS    = 3750
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_ni,
  input  logic       enable_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_frame_err_o,
  output logic       busy_o,
  output logic       serial_tx_o,
  output logic       serial_oe_o,
  input  logic       serial_rx_i
);

  localparam int unsigned CW = cnt_width(CLKS_PER_BIT);
  localparam int unsigned HW = cnt_width(HOLD_CLKS);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CLKS - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(UART_DATA_BITS - 1);

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [HW-1:0] hold_q;
  logic [2:0]    idx_q;
  logic [7:0]    tx_shift_q;
  logic [7:0]    rx_shift_q;
  logic [7:0]    rx_data_q;
  logic          rx_valid_q;
  logic          rx_err_q;
  logic          tx_q;
  logic          oe_q;

  logic rx_sync;
  logic rx_fall;
  logic tx_ready;
  logic tx_accept;

  sync_falling_edge u_sync (
    .clk_i  (wb_clk_i),
    .rst_ni (wb_rst_ni),
    .d_i    (serial_rx_i),
    .sync_o (rx_sync),
    .fall_o (rx_fall)
  );

  // Ready is combinational so a byte offered in the last stop-bit cycle
  // starts the next frame without an idle gap. In IDLE a line that is low or
  // just fell belongs to RX, so TX never wins against an incoming start bit.
  always_comb begin
    tx_ready = 1'b0;
    if (wb_rst_ni && enable_i) begin
      case (state_q)
        IDLE:    tx_ready = rx_sync & ~rx_fall;
        TX_STOP: tx_ready = (cnt_q == BIT_LAST);
        TX_HOLD: tx_ready = 1'b1;
        default: tx_ready = 1'b0;
      endcase
    end
  end

  assign tx_accept = tx_valid_i & tx_ready;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hold_q     <= '0;
      idx_q      <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      tx_q       <= 1'b1;
      oe_q       <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      if (!enable_i) begin
        state_q <= IDLE;
        tx_q    <= 1'b1;
        oe_q    <= 1'b0;
        cnt_q   <= '0;
        hold_q  <= '0;
        idx_q   <= '0;
      end else if (tx_accept) begin
        // Taken from IDLE, the last stop cycle, or the hold window alike.
        state_q    <= TX_START;
        tx_shift_q <= tx_data_i;
        tx_q       <= 1'b0;
        oe_q       <= 1'b1;
        cnt_q      <= '0;
        hold_q     <= '0;
        idx_q      <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            tx_q <= 1'b1;
            oe_q <= 1'b0;
            if (rx_fall) begin
              state_q <= RX_START;
              cnt_q   <= '0;
            end
          end
          TX_START: begin
            if (cnt_q == BIT_LAST) begin
              cnt_q      <= '0;
              idx_q      <= '0;
              state_q    <= TX_DATA;
              tx_q       <= tx_shift_q[0];
              tx_shift_q <= {1'b1, tx_shift_q[7:1]};
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          TX_DATA: begin
            if (cnt_q == BIT_LAST) begin
              cnt_q <= '0;
              if (idx_q == IDX_LAST) begin
                state_q <= TX_STOP;
                tx_q    <= 1'b1;
              end else begin
                idx_q      <= idx_q + 3'd1;
                tx_q       <= tx_shift_q[0];
                tx_shift_q <= {1'b1, tx_shift_q[7:1]};
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          TX_STOP: begin
            if (cnt_q == BIT_LAST) begin
              cnt_q   <= '0;
              hold_q  <= '0;
              state_q <= TX_HOLD;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          TX_HOLD: begin
            if (hold_q == HOLD_LAST) begin
              state_q <= IDLE;
              oe_q    <= 1'b0;
            end else begin
              hold_q <= hold_q + HW'(1);
            end
          end
          RX_START: begin
            if (cnt_q == HALF_LAST) begin
              cnt_q <= '0;
              idx_q <= '0;
              // A start bit that is high again at its midpoint was noise.
              state_q <= rx_sync ? IDLE : RX_DATA;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          RX_DATA: begin
            if (cnt_q == BIT_LAST) begin
              cnt_q      <= '0;
              rx_shift_q <= {rx_sync, rx_shift_q[7:1]};
              if (idx_q == IDX_LAST) begin
                state_q <= RX_STOP;
              end else begin
                idx_q <= idx_q + 3'd1;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          RX_STOP: begin
            if (cnt_q == BIT_LAST) begin
              cnt_q   <= '0;
              state_q <= IDLE;
              if (rx_sync) begin
                rx_data_q  <= rx_shift_q;
                rx_valid_q <= 1'b1;
              end else begin
                rx_err_q <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign tx_ready_o     = tx_ready;
  assign rx_data_o      = rx_data_q;
  assign rx_valid_o     = rx_valid_q;
  assign rx_frame_err_o = rx_err_q;
  assign busy_o         = (state_q != IDLE);
  assign serial_tx_o    = tx_q;
  assign serial_oe_o    = oe_q;

endmodule

// File: tb/tb_onewire_uart_bridge.sv
// Self-checking bench for onewire_uart_bridge. The pad is modelled as a
// loopback: while the bridge drives, the sampled line equals its own drive.
module tb_onewire_uart_bridge;

  localparam int unsigned CPB   = 8;
  localparam int unsigned HOLD  = 16;
  localparam int unsigned FRAME = 10 * CPB;

  logic       wb_clk   = 1'b0;
  logic       wb_rst_n = 1'b0;
  logic       enable   = 1'b0;
  logic [7:0] tx_data  = '0;
  logic       tx_valid = 1'b0;
  logic       rx_drv   = 1'b1;
  logic       tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_frame_err_o;
  logic       busy_o;
  logic       serial_tx_o;
  logic       serial_oe_o;
  logic       serial_rx;

  int checks = 0;
  int errors = 0;
  int nv = 0;
  int ne = 0;
  int nboth = 0;
  logic [7:0] exp_rx = '0;
  logic [7:0] tx_bytes [4];

  assign serial_rx = serial_oe_o ? serial_tx_o : rx_drv;

  onewire_uart_bridge #(
    .CLKS_PER_BIT (CPB),
    .HOLD_CLKS    (HOLD)
  ) dut (
    .wb_clk_i       (wb_clk),
    .wb_rst_ni      (wb_rst_n),
    .enable_i       (enable),
    .tx_data_i      (tx_data),
    .tx_valid_i     (tx_valid),
    .tx_ready_o     (tx_ready_o),
    .rx_data_o      (rx_data_o),
    .rx_valid_o     (rx_valid_o),
    .rx_frame_err_o (rx_frame_err_o),
    .busy_o         (busy_o),
    .serial_tx_o    (serial_tx_o),
    .serial_oe_o    (serial_oe_o),
    .serial_rx_i    (serial_rx)
  );

  always #5 wb_clk = ~wb_clk;

  // Pulse counters: each pulse is exactly one cycle wide.
  always @(posedge wb_clk) begin
    if (rx_valid_o) nv++;
    if (rx_frame_err_o) ne++;
    if (rx_valid_o && rx_frame_err_o) nboth++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    wb_rst_n = 1'b0;
    enable   = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'($urandom);
    repeat (3) @(negedge wb_clk);
    checks++; if (serial_tx_o !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", serial_tx_o); end
    checks++; if (serial_oe_o !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", serial_oe_o); end
    checks++; if (tx_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", tx_ready_o); end
    checks++; if (rx_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid_o); end
    checks++; if (rx_frame_err_o !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", rx_frame_err_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    checks++; if (rx_data_o !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data_o); end
    tx_valid = 1'b0;
    wb_rst_n = 1'b1;
    repeat (4) @(negedge wb_clk);
    checks++; if (tx_ready_o !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b want 1", tx_ready_o); end
  endtask

  // Offers tx_bytes[0] and returns at the negedge where tx_ready_o is seen,
  // so the byte is taken at the following posedge.
  task automatic tx_offer_wait(output bit ok);
    ok = 1'b0;
    @(negedge wb_clk);
    tx_data  = tx_bytes[0];
    tx_valid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (tx_ready_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge wb_clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL tx_accept_timeout: ready never seen, want accept within 200 cycles");
      tx_valid = 1'b0;
    end
  endtask

  // Reference: n frames back to back, each 10 bit slots of CPB cycles
  // (start 0, data LSB first, stop 1), then HOLD idle-high cycles, OE high
  // throughout. j counts cycles after the first acceptance edge.
  task automatic tx_frames_check(input int n);
    int unsigned total;
    int unsigned f;
    int unsigned k;
    int sent;
    int nv0;
    int ne0;
    bit pend;
    logic [9:0] fr;
    logic exp_tx, exp_oe, exp_rdy;
    total = FRAME * n;
    sent = 0;
    pend = 1'b1;
    nv0 = 0;
    ne0 = 0;
    for (int unsigned j = 1; j <= total + HOLD + 4; j++) begin
      @(negedge wb_clk);
      if (j == 1) begin
        nv0 = nv;
        ne0 = ne;
      end
      if (pend) begin
        sent++;
        if (sent < n) tx_data = tx_bytes[sent];
        else tx_valid = 1'b0;
      end
      exp_oe = (j <= total + HOLD);
      if (j <= total) begin
        f = (j - 1) / FRAME;
        k = ((j - 1) % FRAME) / CPB;
        fr = {1'b1, tx_bytes[f], 1'b0};
        exp_tx = fr[k];
      end else begin
        exp_tx = 1'b1;
      end
      exp_rdy = (j >= total) || (j % FRAME == 0);
      checks++; if (serial_tx_o !== exp_tx) begin errors++; $display("FAIL tx_line j=%0d: got %b want %b", j, serial_tx_o, exp_tx); end
      checks++; if (serial_oe_o !== exp_oe) begin errors++; $display("FAIL tx_oe j=%0d: got %b want %b", j, serial_oe_o, exp_oe); end
      checks++; if (tx_ready_o !== exp_rdy) begin errors++; $display("FAIL tx_ready j=%0d: got %b want %b", j, tx_ready_o, exp_rdy); end
      checks++; if (busy_o !== exp_oe) begin errors++; $display("FAIL tx_busy j=%0d: got %b want %b", j, busy_o, exp_oe); end
      pend = tx_valid && tx_ready_o;
    end
    repeat (2) @(negedge wb_clk);
    checks++; if (sent != n) begin errors++; $display("FAIL tx_sent_count: got %0d want %0d", sent, n); end
    checks++; if (nv != nv0 || ne != ne0) begin errors++; $display("FAIL tx_echo: got %0d/%0d rx pulses want 0/0", nv - nv0, ne - ne0); end
  endtask

  task automatic tx_run(input int n);
    bit ok;
    tx_offer_wait(ok);
    if (ok) tx_frames_check(n);
  endtask

  task automatic test_tx();
    tx_bytes[0] = 8'hA5;
    tx_run(1);
    for (int i = 0; i < 2; i++) begin
      tx_bytes[0] = 8'($urandom);
      tx_run(1);
    end
  endtask

  task automatic test_back_to_back();
    tx_bytes[0] = 8'h55;
    tx_bytes[1] = 8'h0F;
    tx_run(2);
    for (int i = 0; i < 3; i++) tx_bytes[i] = 8'($urandom);
    tx_run(3);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int unsigned c = 0; c < FRAME; c++) begin
      @(negedge wb_clk);
      rx_drv = fr[c / CPB];
    end
    @(negedge wb_clk);
    rx_drv = 1'b1;
    repeat (20) @(negedge wb_clk);
  endtask

  task automatic test_rx();
    logic [7:0] b;
    int nv0, ne0;
    for (int i = 0; i < 4; i++) begin
      b = (i == 0) ? 8'h3C : 8'($urandom);
      nv0 = nv;
      ne0 = ne;
      rx_frame(b, 1'b1);
      exp_rx = b;
      checks++; if (nv - nv0 != 1) begin errors++; $display("FAIL rx_valid_count: got %0d want 1", nv - nv0); end
      checks++; if (ne != ne0) begin errors++; $display("FAIL rx_no_err: got %0d want 0", ne - ne0); end
      checks++; if (rx_data_o !== exp_rx) begin errors++; $display("FAIL rx_data: got %h want %h", rx_data_o, exp_rx); end
    end
  endtask

  task automatic test_frame_err();
    logic [7:0] b;
    int nv0, ne0;
    for (int i = 0; i < 2; i++) begin
      b = (i == 0) ? 8'h81 : 8'($urandom);
      nv0 = nv;
      ne0 = ne;
      rx_frame(b, 1'b0);
      checks++; if (ne - ne0 != 1) begin errors++; $display("FAIL ferr_count: got %0d want 1", ne - ne0); end
      checks++; if (nv != nv0) begin errors++; $display("FAIL ferr_no_valid: got %0d want 0", nv - nv0); end
      checks++; if (rx_data_o !== exp_rx) begin errors++; $display("FAIL ferr_data_hold: got %h want %h", rx_data_o, exp_rx); end
    end
  endtask

  task automatic test_glitch();
    int nv0, ne0;
    bit saw_busy;
    nv0 = nv;
    ne0 = ne;
    saw_busy = 1'b0;
    @(negedge wb_clk);
    rx_drv = 1'b0;
    repeat (3) @(negedge wb_clk);
    rx_drv = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge wb_clk);
      if (busy_o) saw_busy = 1'b1;
    end
    checks++; if (saw_busy !== 1'b1) begin errors++; $display("FAIL glitch_seen: got busy %b want 1", saw_busy); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL glitch_idle: got busy %b want 0", busy_o); end
    checks++; if (nv != nv0 || ne != ne0) begin errors++; $display("FAIL glitch_pulses: got %0d/%0d want 0/0", nv - nv0, ne - ne0); end
  endtask

  // A byte offered when the RX start edge is detected must wait for RX.
  task automatic test_contention();
    logic [7:0] rb;
    logic [9:0] fr;
    bit rx_done, accepted;
    rb = 8'($urandom);
    fr = {1'b1, rb, 1'b0};
    tx_bytes[0] = 8'($urandom);
    rx_done = 1'b0;
    accepted = 1'b0;
    for (int unsigned c = 0; c < FRAME + 40; c++) begin
      @(negedge wb_clk);
      rx_drv = (c < FRAME) ? fr[c / CPB] : 1'b1;
      if (c == 2) tx_valid = 1'b1;
      if (rx_valid_o) rx_done = 1'b1;
      if (tx_valid) begin
        tx_data = tx_ready_o ? tx_bytes[0] : 8'($urandom);
        if (tx_ready_o) begin
          checks++;
          if (!rx_done) begin
            errors++;
            $display("FAIL contention_early_accept c=%0d: got accept want wait for rx", c);
          end
          accepted = 1'b1;
          break;
        end
      end
    end
    checks++; if (!accepted) begin errors++; $display("FAIL contention_no_accept: got none want accept after rx"); tx_valid = 1'b0; end
    if (accepted) tx_frames_check(1);
    exp_rx = rb;
    checks++; if (rx_data_o !== exp_rx) begin errors++; $display("FAIL contention_rx_data: got %h want %h", rx_data_o, exp_rx); end
  endtask

  task automatic test_abort(input bit use_reset);
    bit ok;
    tx_bytes[0] = 8'($urandom);
    tx_offer_wait(ok);
    if (ok) begin
      for (int j = 1; j <= 44; j++) begin
        @(negedge wb_clk);
        if (j == 1) tx_valid = 1'b0;
      end
      checks++; if (serial_oe_o !== 1'b1 || busy_o !== 1'b1) begin errors++; $display("FAIL abort_midframe: got oe %b busy %b want 1 1", serial_oe_o, busy_o); end
      if (use_reset) wb_rst_n = 1'b0;
      else enable = 1'b0;
      @(negedge wb_clk);
      checks++; if (serial_oe_o !== 1'b0) begin errors++; $display("FAIL abort_oe: got %b want 0", serial_oe_o); end
      checks++; if (serial_tx_o !== 1'b1) begin errors++; $display("FAIL abort_tx: got %b want 1", serial_tx_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy_o); end
      checks++; if (tx_ready_o !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b want 0", tx_ready_o); end
      if (use_reset) begin
        exp_rx = 8'h00;
        checks++; if (rx_data_o !== exp_rx) begin errors++; $display("FAIL abort_rx_data: got %h want %h", rx_data_o, exp_rx); end
      end
      wb_rst_n = 1'b1;
      enable = 1'b1;
      repeat (5) @(negedge wb_clk);
    end
    tx_bytes[0] = 8'($urandom);
    tx_run(1);
  endtask

  initial begin
    test_reset();
    test_tx();
    test_back_to_back();
    test_rx();
    test_frame_err();
    test_glitch();
    test_contention();
    test_abort(1'b0);
    test_abort(1'b1);
    checks++; if (nboth != 0) begin errors++; $display("FAIL valid_err_overlap: got %0d want 0", nboth); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
